// File: rtl/seek_motion_model.sv
// Head-carriage motion model for the emulated pack drive.
// Steps the modelled head one cylinder every STEP_CYCLES clocks toward the latched target.
// It then waits SETTLE_CYCLES before reporting on-cylinder. A new accepted strobe restarts
// motion from the current cylinder at any time.
module seek_motion_model #(
    parameter int unsigned STEP_CYCLES   = 10,
    parameter int unsigned SETTLE_CYCLES = 25,
    parameter int unsigned MAX_CYL       = 407
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       seek_strobe_i,
    input  logic [8:0] cyl_addr_i,
    input  logic       seek_error_i,
    output logic [8:0] cur_cyl_o,
    output logic [8:0] target_cyl_o,
    output logic       dir_o,
    output logic       step_pulse_o,
    output logic       seeking_o,
    output logic       on_cyl_o,
    output logic       seek_done_o
);

    localparam int unsigned CntMax =
        (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] StepLast   = CntW'(STEP_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [8:0]      MaxCyl     = 9'(MAX_CYL);

    typedef enum logic [1:0] {StIdle, StStep, StSettle} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [8:0]      cur_cyl_q;
    logic [8:0]      target_cyl_q;
    logic            dir_q;
    logic            step_pulse_q;
    logic            seeking_q;
    logic            settled_q;   // internal on-cylinder, before seek_error masking
    logic            on_cyl_q;
    logic            seek_done_q;

    logic            accept;
    logic            at_limit;
    logic [8:0]      next_cyl;

    // Strobe qualification and the neighbouring cylinder in the current direction.
    always_comb begin
        accept   = seek_strobe_i && (cyl_addr_i <= MaxCyl);
        next_cyl = dir_q ? (cur_cyl_q + 9'd1) : (cur_cyl_q - 9'd1);
        at_limit = dir_q ? (cur_cyl_q == MaxCyl) : (cur_cyl_q == 9'd0);
    end

    // Motion FSM with all outputs registered; an accepted strobe overrides any step in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            cur_cyl_q    <= '0;
            target_cyl_q <= '0;
            dir_q        <= 1'b1;
            step_pulse_q <= 1'b0;
            seeking_q    <= 1'b0;
            settled_q    <= 1'b1;
            on_cyl_q     <= ~seek_error_i;
            seek_done_q  <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            seek_done_q  <= 1'b0;
            on_cyl_q     <= settled_q & ~seek_error_i;
            if (accept) begin
                target_cyl_q <= cyl_addr_i;
                cnt_q        <= '0;
                seeking_q    <= 1'b1;
                settled_q    <= 1'b0;
                on_cyl_q     <= 1'b0;
                if (cyl_addr_i > cur_cyl_q) begin
                    dir_q   <= 1'b1;
                    state_q <= StStep;
                end else if (cyl_addr_i < cur_cyl_q) begin
                    dir_q   <= 1'b0;
                    state_q <= StStep;
                end else begin
                    state_q <= StSettle;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        cnt_q <= '0;
                    end
                    StStep: begin
                        if (cnt_q == StepLast) begin
                            cnt_q <= '0;
                            // Never step past the legal range; treat the edge as arrival.
                            if (at_limit) begin
                                state_q <= StSettle;
                            end else begin
                                cur_cyl_q    <= next_cyl;
                                step_pulse_q <= 1'b1;
                                if (next_cyl == target_cyl_q) begin
                                    state_q <= StSettle;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StSettle: begin
                        if (cnt_q == SettleLast) begin
                            state_q     <= StIdle;
                            cnt_q       <= '0;
                            seeking_q   <= 1'b0;
                            settled_q   <= 1'b1;
                            on_cyl_q    <= ~seek_error_i;
                            seek_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign cur_cyl_o    = cur_cyl_q;
    assign target_cyl_o = target_cyl_q;
    assign dir_o        = dir_q;
    assign step_pulse_o = step_pulse_q;
    assign seeking_o    = seeking_q;
    assign on_cyl_o     = on_cyl_q;
    assign seek_done_o  = seek_done_q;

endmodule

// File: tb/tb_seek_motion_model.sv
// Bench for seek_motion_model: directed table, a terminal-count corner and random traffic.
// Every edge is also compared against a timing-formula reference model.
module tb_seek_motion_model;

    localparam int STEP    = 4;
    localparam int SETTLE  = 6;
    localparam int MAX_CYL = 407;

    logic       clk;
    logic       reset;
    logic       seek_strobe;
    logic [8:0] cyl_addr;
    logic       seek_error;
    logic [8:0] cur_cyl;
    logic [8:0] target_cyl;
    logic       dir;
    logic       step_pulse;
    logic       seeking;
    logic       on_cyl;
    logic       seek_done;

    seek_motion_model #(
        .STEP_CYCLES   (STEP),
        .SETTLE_CYCLES (SETTLE),
        .MAX_CYL       (MAX_CYL)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .seek_strobe_i (seek_strobe),
        .cyl_addr_i    (cyl_addr),
        .seek_error_i  (seek_error),
        .cur_cyl_o     (cur_cyl),
        .target_cyl_o  (target_cyl),
        .dir_o         (dir),
        .step_pulse_o  (step_pulse),
        .seeking_o     (seeking),
        .on_cyl_o      (on_cyl),
        .seek_done_o   (seek_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Directed row: inputs for one edge, then `idle` further quiet edges, then expectations.
    typedef struct {
        int rst; int stb; int addr; int err; int idle;
        int cur; int tgt; int dir; int step; int seek; int on; int done; int ndone;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_no = 0;
    int   done_cnt = 0;

    // Reference model: a seek is described by its start edge, start cylinder and distance.
    // Outputs follow from elapsed edges k since acceptance.
    int   m_k = 0;
    int   m_p0 = 0;
    int   m_tg = 0;
    int   m_dist = 0;
    int   m_dir = 1;
    int   m_rst_mode = 1;
    int   m_cur = 0;
    int   e_step = 0;
    int   e_seek = 0;
    int   e_on = 1;
    int   e_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit stb, input int addr, input bit err);
        int steps;
        int off;
        int on_int;
        if (rst) begin
            m_rst_mode = 1; m_p0 = 0; m_tg = 0; m_dir = 1; m_dist = 0; m_k = 0;
        end else if (stb && addr <= MAX_CYL) begin
            m_p0 = m_cur;
            m_tg = addr;
            if (m_tg > m_p0) m_dir = 1;
            else if (m_tg < m_p0) m_dir = 0;
            m_dist = (m_tg > m_p0) ? m_tg - m_p0 : m_p0 - m_tg;
            m_k = 0;
            m_rst_mode = 0;
        end else begin
            m_k++;
        end
        if (m_rst_mode != 0) begin
            m_cur = 0; e_step = 0; e_seek = 0; on_int = 1; e_done = 0;
        end else begin
            steps = m_k / STEP;
            if (steps > m_dist) steps = m_dist;
            m_cur  = (m_dir != 0) ? m_p0 + steps : m_p0 - steps;
            off    = m_dist * STEP + SETTLE;
            e_step = (m_k > 0 && m_k % STEP == 0 && m_k / STEP <= m_dist) ? 1 : 0;
            e_seek = (m_k < off) ? 1 : 0;
            on_int = (m_k >= off) ? 1 : 0;
            e_done = (m_k == off) ? 1 : 0;
        end
        e_on = (on_int != 0 && !err) ? 1 : 0;
    endtask

    task automatic tick(input bit rst, input bit stb, input int addr, input bit err);
        reset       = rst;
        seek_strobe = stb;
        cyl_addr    = 9'(addr);
        seek_error  = err;
        @(posedge clk);
        edge_no++;
        model_step(rst, stb, addr, err);
        #1;
        chk("model cur_cyl", 32'(cur_cyl), m_cur);
        chk("model target_cyl", 32'(target_cyl), m_tg);
        chk("model dir", 32'(dir), m_dir);
        chk("model step_pulse", 32'(step_pulse), e_step);
        chk("model seeking", 32'(seeking), e_seek);
        chk("model on_cyl", 32'(on_cyl), e_on);
        chk("model seek_done", 32'(seek_done), e_done);
        if (seek_done === 1'b1) done_cnt++;
        reset       = 1'b0;
        seek_strobe = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   a;
        bit   r_rst;
        bit   r_stb;
        bit   err_r;

        reset = 1'b1; seek_strobe = 1'b0; cyl_addr = '0; seek_error = 1'b0;

        // rst stb addr err idle | cur tgt dir step seek on done ndone
        tbl.push_back('{1, 0,   0, 0, 10,  0,   0, 1, 0, 0, 1, 0,  0});
        tbl.push_back('{0, 1,   3, 0,  0,  0,   3, 1, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  2,  0,   3, 1, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  0,  1,   3, 1, 1, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  3,  2,   3, 1, 1, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  3,  3,   3, 1, 1, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  4,  3,   3, 1, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  0,  3,   3, 1, 0, 0, 1, 1,  1});
        tbl.push_back('{0, 0,   0, 0,  0,  3,   3, 1, 0, 0, 1, 0, -1});
        // zero-distance seek: settle only
        tbl.push_back('{0, 1,   3, 0,  0,  3,   3, 1, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  4,  3,   3, 1, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  0,  3,   3, 1, 0, 0, 1, 1,  2});
        // retarget with reversal
        tbl.push_back('{1, 0,   0, 0,  0,  0,   0, 1, 0, 0, 1, 0, -1});
        tbl.push_back('{0, 1,  10, 0,  0,  0,  10, 1, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  7,  2,  10, 1, 1, 1, 0, 0, -1});
        tbl.push_back('{0, 1,   0, 0,  0,  2,   0, 0, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  3,  1,   0, 0, 1, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  3,  0,   0, 0, 1, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  4,  0,   0, 0, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  0,  0,   0, 0, 0, 0, 1, 1,  1});
        // out-of-range strobe ignored, then seek_error masking with one-clock lag
        tbl.push_back('{0, 1,   5, 0, 27,  5,   5, 1, 0, 0, 1, 0,  2});
        tbl.push_back('{0, 1, 408, 0,  0,  5,   5, 1, 0, 0, 1, 0, -1});
        tbl.push_back('{0, 0,   0, 1,  0,  5,   5, 1, 0, 0, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 1,  0,  5,   5, 1, 0, 0, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 1,  0,  5,   5, 1, 0, 0, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  0,  5,   5, 1, 0, 0, 1, 0,  2});
        // reset in the middle of a seek
        tbl.push_back('{1, 0,   0, 0,  0,  0,   0, 1, 0, 0, 1, 0, -1});
        tbl.push_back('{0, 1,  20, 0,  0,  0,  20, 1, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0, 27,  7,  20, 1, 1, 1, 0, 0, -1});
        tbl.push_back('{1, 0,   0, 0,  0,  0,   0, 1, 0, 0, 1, 0, -1});
        tbl.push_back('{0, 0,   0, 0, 30,  0,   0, 1, 0, 0, 1, 0,  0});
        // MAX_CYL target accepted, then immediately retargeted to the current cylinder
        tbl.push_back('{0, 1, 407, 0,  0,  0, 407, 1, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 1,   0, 0,  0,  0,   0, 1, 0, 1, 0, 0, -1});
        tbl.push_back('{0, 0,   0, 0,  5,  0,   0, 1, 0, 0, 1, 1,  1});

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            tick(v.rst != 0, v.stb != 0, v.addr, v.err != 0);
            if (v.rst != 0) done_cnt = 0;
            for (int j = 0; j < v.idle; j++) tick(1'b0, 1'b0, 0, v.err != 0);
            chk($sformatf("row%0d cur_cyl", i), 32'(cur_cyl), v.cur);
            chk($sformatf("row%0d target_cyl", i), 32'(target_cyl), v.tgt);
            chk($sformatf("row%0d dir", i), 32'(dir), v.dir);
            chk($sformatf("row%0d step_pulse", i), 32'(step_pulse), v.step);
            chk($sformatf("row%0d seeking", i), 32'(seeking), v.seek);
            chk($sformatf("row%0d on_cyl", i), 32'(on_cyl), v.on);
            chk($sformatf("row%0d seek_done", i), 32'(seek_done), v.done);
            if (v.ndone >= 0) chk($sformatf("row%0d seek_done count", i), done_cnt, v.ndone);
        end

        // Strobe landing on a step terminal count: strobe wins, no step on that edge.
        tick(1'b0, 1'b1, 5, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 0, 1'b0);
        tick(1'b0, 1'b1, 9, 1'b0);
        chk("tc cur_cyl", 32'(cur_cyl), 0);
        chk("tc step_pulse", 32'(step_pulse), 0);
        chk("tc target_cyl", 32'(target_cyl), 9);
        repeat (4) tick(1'b0, 1'b0, 0, 1'b0);
        chk("tc first step cur_cyl", 32'(cur_cyl), 1);
        chk("tc first step_pulse", 32'(step_pulse), 1);

        // Random traffic against the reference model.
        tick(1'b1, 1'b0, 0, 1'b0);
        err_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 699) == 0);
            r_stb = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) a = int'($urandom_range(408, 511));
            else a = int'($urandom_range(0, 14));
            if ($urandom_range(0, 15) == 0) err_r = ~err_r;
            tick(r_rst, r_stb, a, err_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
